// File: rtl/exec_unit.sv
// Execute-stage arithmetic: ALU-control decode, 32-bit ALU with zero flag, PC+4 and branch-target adders.
// Latency: gout/result/zero/pc_plus4/branch_target are combinational; result_q/zero_q lag by one clk edge.
// Backpressure: none; the block accepts new operands every cycle and never stalls.
//
// Ports:
//   clk, reset          : clock and synchronous active-high reset (debug registers only)
//   aluop, fsel, rt_lsb : ALUOp from main control, funct/opcode select, REGIMM rt[0]
//   a, b                : ALU operands
//   pc, imm_ext         : program counter and sign-extended immediate for the adders
//   gout                : decoded ALU operation
//   result, zero        : ALU result and result==0 flag
//   pc_plus4            : pc + 4
//   branch_target       : pc_plus4 + (imm_ext << 2)
//   result_q, zero_q    : registered copies of result and zero
module exec_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  aluop,
  input  logic [3:0]  fsel,
  input  logic        rt_lsb,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] pc,
  input  logic [31:0] imm_ext,
  output logic [3:0]  gout,
  output logic [31:0] result,
  output logic        zero,
  output logic [31:0] pc_plus4,
  output logic [31:0] branch_target,
  output logic [31:0] result_q,
  output logic        zero_q
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_NEQ  = 4'b1001;
  localparam logic [3:0] OP_GEZ  = 4'b1010;
  localparam logic [3:0] OP_LTZ  = 4'b1011;

  // ALU-control decode
  always_comb begin
    gout = OP_ADD;
    unique case (aluop)
      2'b00: gout = OP_ADD;
      2'b01: begin
        case (fsel)
          4'b0100: gout = OP_SUB;
          4'b0101: gout = OP_NEQ;
          4'b0001: gout = rt_lsb ? OP_GEZ : OP_LTZ;
          default: gout = OP_SUB;
        endcase
      end
      2'b10: begin
        case (fsel)
          4'b0000, 4'b0001: gout = OP_ADD;
          4'b0010, 4'b0011: gout = OP_SUB;
          4'b0100:          gout = OP_AND;
          4'b0101:          gout = OP_OR;
          4'b0110:          gout = OP_XOR;
          4'b0111:          gout = OP_NOR;
          4'b1010:          gout = OP_SLT;
          4'b1011:          gout = OP_SLTU;
          default:          gout = OP_ADD;   // includes JR
        endcase
      end
      2'b11: begin
        case (fsel)
          4'b1010: gout = OP_SLT;
          4'b1011: gout = OP_SLTU;
          4'b1100: gout = OP_AND;
          4'b1101: gout = OP_OR;
          4'b1110: gout = OP_XOR;
          default: gout = OP_ADD;            // includes ADDI
        endcase
      end
      default: gout = OP_ADD;
    endcase
  end

  // ALU. The three branch-compare ops produce an inverted sense so that
  // zero==1 is the branch-taken condition and upstream can use branch & zero
  // for every branch: NEQ yields 1 when equal (zero=1 means not equal),
  // GEZ yields the sign bit, LTZ its complement.
  always_comb begin
    result = 32'h0;
    case (gout)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_ADD:  result = a + b;
      OP_XOR:  result = a ^ b;
      OP_NOR:  result = ~(a | b);
      OP_SUB:  result = a - b;
      OP_SLT:  result = {31'b0, $signed(a) < $signed(b)};
      OP_SLTU: result = {31'b0, a < b};
      OP_NEQ:  result = {31'b0, a == b};
      OP_GEZ:  result = {31'b0, a[31]};
      OP_LTZ:  result = {31'b0, ~a[31]};
      default: result = 32'h0;
    endcase
  end

  assign zero = ~|result;

  // Address adders; carry-out discarded.
  assign pc_plus4      = pc + 32'h4;
  assign branch_target = pc_plus4 + {imm_ext[29:0], 2'b00};

  // Debug/trace capture of the ALU outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= 32'h0;
      zero_q   <= 1'b0;
    end else begin
      result_q <= result;
      zero_q   <= zero;
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Testbench for exec_unit: directed test-plan vectors plus randomized operands
// checked against a behavioural model of the decode and ALU rules.
module tb_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  aluop;
  logic [3:0]  fsel;
  logic        rt_lsb;
  logic [31:0] a, b, pc, imm_ext;
  logic [3:0]  gout;
  logic [31:0] result, pc_plus4, branch_target, result_q;
  logic        zero, zero_q;

  int checks   = 0;
  int failures = 0;

  exec_unit dut (
    .clk(clk), .reset(reset), .aluop(aluop), .fsel(fsel), .rt_lsb(rt_lsb),
    .a(a), .b(b), .pc(pc), .imm_ext(imm_ext),
    .gout(gout), .result(result), .zero(zero),
    .pc_plus4(pc_plus4), .branch_target(branch_target),
    .result_q(result_q), .zero_q(zero_q)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [3:0] m_op(input logic [1:0] op, input logic [3:0] f, input logic r);
    if (op == 2'd0) return 4'd2;
    if (op == 2'd1) begin
      if (f == 4'd4) return 4'd6;
      if (f == 4'd5) return 4'd9;
      if (f == 4'd1) return r ? 4'd10 : 4'd11;
      return 4'd6;
    end
    if (op == 2'd2) begin
      if (f <= 4'd1) return 4'd2;
      if (f <= 4'd3) return 4'd6;
      if (f == 4'd4) return 4'd0;
      if (f == 4'd5) return 4'd1;
      if (f == 4'd6) return 4'd3;
      if (f == 4'd7) return 4'd4;
      if (f == 4'd10) return 4'd7;
      if (f == 4'd11) return 4'd8;
      return 4'd2;
    end
    if (f == 4'd10) return 4'd7;
    if (f == 4'd11) return 4'd8;
    if (f == 4'd12) return 4'd0;
    if (f == 4'd13) return 4'd1;
    if (f == 4'd14) return 4'd3;
    return 4'd2;
  endfunction

  function automatic logic [31:0] m_res(input logic [3:0] g, input logic [31:0] x, input logic [31:0] y);
    longint unsigned sx, sy;
    logic lt_s;
    sx = x; sy = y;
    // signed compare from sign bits: differing signs -> x negative wins
    lt_s = (x[31] != y[31]) ? x[31] : (x < y);
    case (g)
      4'd0:  return x & y;
      4'd1:  return x | y;
      4'd2:  return 32'((sx + sy) % 64'h1_0000_0000);
      4'd3:  return x ^ y;
      4'd4:  return ~(x | y);
      4'd6:  return 32'((sx + 64'h1_0000_0000 - sy) % 64'h1_0000_0000);
      4'd7:  return lt_s ? 32'd1 : 32'd0;
      4'd8:  return (sx < sy) ? 32'd1 : 32'd0;
      4'd9:  return (x == y) ? 32'd1 : 32'd0;
      4'd10: return (x[31]) ? 32'd1 : 32'd0;
      4'd11: return (x[31]) ? 32'd0 : 32'd1;
      default: return 32'd0;
    endcase
  endfunction

  task automatic drive(input logic [1:0] op, input logic [3:0] f, input logic r,
                       input logic [31:0] x, input logic [31:0] y);
    aluop = op; fsel = f; rt_lsb = r; a = x; b = y;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1;
    drive(2'b01, 4'b0100, 1'b0, 32'd9, 32'd9);   // SUB equal -> zero=1
    pc = 32'h0; imm_ext = 32'h0;
    @(posedge clk); #1;
    checks++;
    if (result_q !== 32'h0 || zero_q !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: result_q=%h zero_q=%b required 0/0", result_q, zero_q);
    end
    checks++;
    if (zero !== 1'b1 || result !== 32'h0) begin
      failures++;
      $display("FAIL comb_during_reset: result=%h zero=%b required 0/1", result, zero);
    end
  endtask

  typedef struct {
    logic [1:0]  op; logic [3:0] f; logic r;
    logic [31:0] x, y;
    logic [3:0]  eg; logic [31:0] er; logic ez;
  } vec_t;

  task automatic test_directed;
    vec_t v[12];
    v[0]  = '{2'b00, 4'b1111, 1'b0, 32'h10,       32'hFFFFFFFC, 4'b0010, 32'hC,        1'b0};
    v[1]  = '{2'b10, 4'b1010, 1'b0, 32'hFFFFFFFF, 32'h1,        4'b0111, 32'h1,        1'b0};
    v[2]  = '{2'b10, 4'b1011, 1'b0, 32'hFFFFFFFF, 32'h1,        4'b1000, 32'h0,        1'b1};
    v[3]  = '{2'b10, 4'b0111, 1'b0, 32'h0,        32'h0,        4'b0100, 32'hFFFFFFFF, 1'b0};
    v[4]  = '{2'b01, 4'b0100, 1'b0, 32'h5,        32'h5,        4'b0110, 32'h0,        1'b1};
    v[5]  = '{2'b01, 4'b0101, 1'b0, 32'h5,        32'h5,        4'b1001, 32'h1,        1'b0};
    v[6]  = '{2'b01, 4'b0001, 1'b1, 32'h80000000, 32'h0,        4'b1010, 32'h1,        1'b0};
    v[7]  = '{2'b01, 4'b0001, 1'b0, 32'h80000000, 32'h0,        4'b1011, 32'h0,        1'b1};
    v[8]  = '{2'b11, 4'b1101, 1'b0, 32'h0F0F0000, 32'hFF,       4'b0001, 32'h0F0F00FF, 1'b0};
    v[9]  = '{2'b11, 4'b1100, 1'b0, 32'h0F0F0000, 32'hFF,       4'b0000, 32'h0,        1'b1};
    v[10] = '{2'b11, 4'b1110, 1'b0, 32'h0F0F0000, 32'hFF,       4'b0011, 32'h0F0F00FF, 1'b0};
    v[11] = '{2'b00, 4'b0000, 1'b0, 32'h7FFFFFFF, 32'h1,        4'b0010, 32'h80000000, 1'b0};
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(v[i].op, v[i].f, v[i].r, v[i].x, v[i].y);
      #1;
      checks++;
      if (gout !== v[i].eg || result !== v[i].er || zero !== v[i].ez) begin
        failures++;
        $display("FAIL directed_%0d: gout=%b result=%h zero=%b required %b/%h/%b",
                 i, gout, result, zero, v[i].eg, v[i].er, v[i].ez);
      end
    end
  endtask

  task automatic test_adders;
    @(negedge clk);
    pc = 32'h8; imm_ext = 32'hFFFFFFFE; #1;
    checks++;
    if (pc_plus4 !== 32'hC || branch_target !== 32'h4) begin
      failures++;
      $display("FAIL adders_neg_imm: pc_plus4=%h target=%h required 0000000c/00000004", pc_plus4, branch_target);
    end
    pc = 32'hFFFFFFFC; imm_ext = 32'h1; #1;
    checks++;
    if (pc_plus4 !== 32'h0 || branch_target !== 32'h4) begin
      failures++;
      $display("FAIL adders_wrap: pc_plus4=%h target=%h required 00000000/00000004", pc_plus4, branch_target);
    end
  endtask

  task automatic test_registers;
    @(negedge clk);
    reset = 1'b1;
    drive(2'b00, 4'b0000, 1'b0, 32'd1, 32'd1);
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if (result_q !== 32'h0 || zero_q !== 1'b0) begin
        failures++;
        $display("FAIL reg_reset_hold: result_q=%h zero_q=%b required 0/0", result_q, zero_q);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    drive(2'b00, 4'b0000, 1'b0, 32'd3, 32'd4);
    @(posedge clk); #1;
    checks++;
    if (result_q !== 32'd7 || zero_q !== 1'b0) begin
      failures++;
      $display("FAIL reg_capture: result_q=%h zero_q=%b required 00000007/0", result_q, zero_q);
    end
    @(negedge clk);
    drive(2'b10, 4'b0010, 1'b0, 32'd4, 32'd4);   // SUB -> 0, zero=1
    @(posedge clk); #1;
    checks++;
    if (result_q !== 32'd0 || zero_q !== 1'b1) begin
      failures++;
      $display("FAIL reg_capture_zero: result_q=%h zero_q=%b required 0/1", result_q, zero_q);
    end
    @(negedge clk);
    drive(2'b00, 4'b0000, 1'b0, 32'd3, 32'd4);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (result_q !== 32'd0 || zero_q !== 1'b0 || result !== 32'd7) begin
      failures++;
      $display("FAIL reg_midstream_reset: result_q=%h zero_q=%b result=%h required 0/0/7",
               result_q, zero_q, result);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_random;
    logic [3:0]  eg;
    logic [31:0] er, ept, ebt;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      drive(2'($urandom), 4'($urandom), 1'($urandom), $urandom, $urandom);
      case ($urandom_range(0, 3))
        0: b = a;
        1: a = {1'b1, 31'($urandom_range(0, 7))};
        default: ;
      endcase
      pc = $urandom; imm_ext = $urandom;
      #1;
      eg  = m_op(aluop, fsel, rt_lsb);
      er  = m_res(eg, a, b);
      ept = 32'((64'(pc) + 64'd4) % 64'h1_0000_0000);
      ebt = 32'((64'(ept) + 64'(imm_ext) * 64'd4) % 64'h1_0000_0000);
      checks++;
      if (gout !== eg || result !== er || zero !== (er == 32'd0)) begin
        failures++;
        $display("FAIL random_alu_%0d: op=%b f=%b r=%b a=%h b=%h gout=%b result=%h zero=%b required %b/%h/%b",
                 i, aluop, fsel, rt_lsb, a, b, gout, result, zero, eg, er, (er == 32'd0));
      end
      checks++;
      if (pc_plus4 !== ept || branch_target !== ebt) begin
        failures++;
        $display("FAIL random_adders_%0d: pc=%h imm=%h pc_plus4=%h target=%h required %h/%h",
                 i, pc, imm_ext, pc_plus4, branch_target, ept, ebt);
      end
      @(posedge clk); #1;
      checks++;
      if (result_q !== er || zero_q !== (er == 32'd0)) begin
        failures++;
        $display("FAIL random_reg_%0d: result_q=%h zero_q=%b required %h/%b",
                 i, result_q, zero_q, er, (er == 32'd0));
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(2'b00, 4'b0000, 1'b0, 32'h0, 32'h0);
    pc = 32'h0; imm_ext = 32'h0;
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    test_directed();
    test_adders();
    test_registers();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
